apb_master_bridge: RTL and testbench

- APB initiator that turns a simple valid/ready command port into APB3 SETUP/ACCESS transfers on an 8-bit address/data peripheral bus.
- Sits between the core-side interconnect and peripheral slaves such as the APB RAM.
- Decodes the target slave and drives a one-hot PSEL.
- Muxes each slave's PRDATA/PREADY back to the initiator.
- Returns one response per command, with a timeout error on slaves that never respond.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_slave_mux.sv | 29 ++
 rtl/apb_master_bridge.sv | 157 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM state encoding, default bus widths
// and response error codes.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StErr
  } apb_state_e;

  localparam int unsigned ApbAddrW = 8;
  localparam int unsigned ApbDataW = 8;

  localparam logic RspOk  = 1'b0;
  localparam logic RspErr = 1'b1;

endpackage

// File: rtl/apb_slave_mux.sv
// Combinational return-path select: picks one slave's PRDATA/PREADY by index and
// flags indices that do not map to a slave.
module apb_slave_mux #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SLV_W      = 1,
  parameter int unsigned DATA_W     = 8
) (
  input  logic [SLV_W-1:0]             idx_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata_bus_i,
  input  logic [NUM_SLAVES-1:0]        pready_bus_i,
  output logic [DATA_W-1:0]            prdata_o,
  output logic                         pready_o,
  output logic                         idx_bad_o
);

  always_comb begin
    prdata_o = '0;
    pready_o = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (32'(idx_i) == i) begin
        prdata_o = prdata_bus_i[i*DATA_W +: DATA_W];
        pready_o = pready_bus_i[i];
      end
    end
  end

  assign idx_bad_o = (32'(idx_i) >= NUM_SLAVES);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: converts valid/ready commands into SETUP/ACCESS transfers with a
// one-hot PSEL, one response per command and a PREADY timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SLV_W      = 1,
  parameter int unsigned ADDR_W     = ApbAddrW,
  parameter int unsigned DATA_W     = ApbDataW,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [SLV_W-1:0]             cmd_slave,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_error,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_bus,
  input  logic [NUM_SLAVES-1:0]        PREADY_bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  apb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SLV_W-1:0]  idx_q, idx_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [SLV_W-1:0]  mux_idx;
  logic [DATA_W-1:0] sel_prdata;
  logic              sel_pready;
  logic              idx_bad;

  // In IDLE the mux range-checks the incoming index; afterwards it tracks the latched one.
  assign mux_idx = (state_q == StIdle) ? cmd_slave : idx_q;

  apb_slave_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_W      (SLV_W),
    .DATA_W     (DATA_W)
  ) u_slave_mux (
    .idx_i        (mux_idx),
    .prdata_bus_i (PRDATA_bus),
    .pready_bus_i (PREADY_bus),
    .prdata_o     (sel_prdata),
    .pready_o     (sel_pready),
    .idx_bad_o    (idx_bad)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = RspOk;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          idx_d    = cmd_slave;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = idx_bad ? StErr : StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (sel_pready) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = RspOk;
          rsp_rdata_d = pwrite_q ? '0 : sel_prdata;
          state_d     = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = RspErr;
          rsp_rdata_d = '0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StErr: begin
        rsp_valid_d = 1'b1;
        rsp_error_d = RspErr;
        rsp_rdata_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    PSEL = '0;
    if ((state_q == StSetup) || (state_q == StAccess)) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        PSEL[i] = (32'(idx_q) == i);
      end
    end
  end

  assign PENABLE   = (state_q == StAccess);
  assign cmd_ready = (state_q == StIdle);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: RAM slave on port 0, never-ready slave on port 1,
// scoreboarded responses and bus-phase monitor against a transaction-level model.
module tb_apb_master_bridge;

  localparam int unsigned NS = 2;
  localparam int unsigned SW = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [SW-1:0] cmd_slave;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [NS-1:0] PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [NS*DW-1:0] PRDATA_bus;
  logic [NS-1:0]    PREADY_bus;

  apb_master_bridge #(
    .NUM_SLAVES (NS),
    .SLV_W      (SW),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_slave  (cmd_slave),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA_bus (PRDATA_bus),
    .PREADY_bus (PREADY_bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // RAM slave: registers PREADY one cycle after seeing PSEL && PENABLE.
  logic [7:0] slave_mem [256] = '{default: 8'h00};
  logic       pready0;
  logic [7:0] prdata0;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pready0 <= 1'b0;
      prdata0 <= 8'h00;
    end else if (PSEL[0] && PENABLE && !pready0) begin
      pready0 <= 1'b1;
      if (PWRITE) slave_mem[PADDR] <= PWDATA;
      else        prdata0 <= slave_mem[PADDR];
    end else begin
      pready0 <= 1'b0;
    end
  end

  assign PRDATA_bus = {8'h5A, prdata0};
  assign PREADY_bus = {1'b0, pready0};

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } rsp_t;

  typedef struct {
    logic [1:0] slv;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         acc_len;
  } bus_t;

  rsp_t exp_q[$];
  bus_t bus_q[$];
  int   acc_q[$];
  int   rsp_times[$];
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string info);
    checks++;
    errors++;
    $display("FAIL %s %s", name, info);
  endtask

  // Monitor: scoreboard for responses plus SETUP/ACCESS phase checks.
  bus_t       cur;
  rsp_t       r;
  bit         in_xfer = 0;
  int         acc_cnt = 0;
  logic [1:0] e_psel;

  initial begin
    forever begin
      @(negedge PCLK);
      cyc++;
      if (!PRESETn) begin
        acc_q.delete();
        bus_q.delete();
        in_xfer = 0;
      end else begin
        if (rsp_valid) begin
          rsp_times.push_back(cyc);
          if (exp_q.size() == 0) begin
            flag("rsp_unexpected", $sformatf("actual err=%0b rdata=%0h required=none",
                                             rsp_error, rsp_rdata));
          end else begin
            r = exp_q.pop_front();
            chk("rsp_error", 32'(rsp_error), 32'(r.err));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
            if (acc_q.size() == 0) flag("rsp_no_accept", "actual=none required=accept");
            else chk("rsp_latency", 32'(cyc - acc_q.pop_front()), 32'(r.lat));
          end
        end
        if (PSEL != '0) begin
          chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
          if (!PENABLE) begin
            if (in_xfer) flag("setup_back_to_back", "actual=setup required=idle");
            if (bus_q.size() == 0) begin
              flag("psel_unexpected", $sformatf("actual=%0b required=00", PSEL));
            end else begin
              cur     = bus_q.pop_front();
              in_xfer = 1;
              acc_cnt = 0;
              e_psel  = 2'b01 << cur.slv;
              chk("setup_psel", 32'(PSEL), 32'(e_psel));
              chk("setup_paddr", 32'(PADDR), 32'(cur.a));
              chk("setup_pwrite", 32'(PWRITE), 32'(cur.w));
              chk("setup_pwdata", 32'(PWDATA), 32'(cur.d));
            end
          end else if (!in_xfer) begin
            flag("access_no_setup", "actual=access required=setup");
          end else begin
            acc_cnt++;
            chk("access_psel", 32'(PSEL), 32'(e_psel));
            chk("access_paddr", 32'(PADDR), 32'(cur.a));
            chk("access_pwdata", 32'(PWDATA), 32'(cur.d));
          end
        end else if (in_xfer) begin
          chk("access_cycles", 32'(acc_cnt), 32'(cur.acc_len));
          chk("penable_drop", 32'(PENABLE), 32'd0);
          in_xfer = 0;
        end
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      end
    end
  end

  // Drive one command from posedge+1; returns just after its accept edge.
  task automatic issue(input logic w, input logic [1:0] s, input logic [7:0] a,
                       input logic [7:0] d, input bit hold, input bit expect_rsp);
    rsp_t e;
    bus_t b;
    bit   acc;
    int   n;
    cmd_write = w;
    cmd_slave = s;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    b.slv = s; b.w = w; b.a = a; b.d = d; b.acc_len = 0;
    if (s == 2'd0) begin
      b.acc_len = 2;
      e.err     = 1'b0;
      e.lat     = 4;
      if (w) begin
        e.rdata = 8'h00;
        if (expect_rsp) ref_mem[a] = d;
      end else begin
        e.rdata = ref_mem[a];
      end
    end else if (s == 2'd1) begin
      b.acc_len = TO;
      e.err     = 1'b1;
      e.rdata   = 8'h00;
      e.lat     = TO + 2;
    end else begin
      e.err   = 1'b1;
      e.rdata = 8'h00;
      e.lat   = 2;
    end
    if (s < 2'd2) bus_q.push_back(b);
    if (expect_rsp) exp_q.push_back(e);
    acc = 0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge PCLK);
      acc = cmd_ready && PRESETn;
      @(posedge PCLK);
      #1;
      n++;
    end
    if (!acc) flag("accept_timeout", "actual=no_accept required=accept");
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    if (exp_q.size() != 0) flag("drain_timeout", $sformatf("actual=%0d required=0", exp_q.size()));
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       w;
    logic [1:0] s;
    int         sel;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_slave = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", 32'(PWDATA), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    issue(1'b1, 2'd0, 8'h10, 8'hA5, 0, 1);
    drain();
    issue(1'b0, 2'd0, 8'h10, 8'h00, 0, 1);
    drain();
    issue(1'b1, 2'd1, 8'h20, 8'h77, 0, 1);
    drain();
    issue(1'b1, 2'd3, 8'h30, 8'h11, 0, 1);
    drain();

    rsp_times.delete();
    issue(1'b1, 2'd0, 8'h00, 8'h01, 1, 1);
    issue(1'b1, 2'd0, 8'h01, 8'h02, 1, 1);
    issue(1'b1, 2'd0, 8'h02, 8'h03, 0, 1);
    drain();
    chk("b2b_rsp_count", 32'(rsp_times.size()), 32'd3);
    if (rsp_times.size() == 3) begin
      chk("b2b_gap0", 32'(rsp_times[1] - rsp_times[0]), 32'd4);
      chk("b2b_gap1", 32'(rsp_times[2] - rsp_times[1]), 32'd4);
    end
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 2'd0, 8'(i), 8'h00, 0, 1);
      drain();
    end

    // Reset during the second ACCESS cycle of a read: no response may follow.
    issue(1'b0, 2'd0, 8'h10, 8'h00, 0, 0);
    @(posedge PCLK);
    #1;
    @(posedge PCLK);
    #1;
    chk("pre_reset_penable", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(PSEL), 32'd0);
    chk("mid_rst_penable", 32'(PENABLE), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (10) @(posedge PCLK);
    #1;

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      s   = (sel <= 6) ? 2'd0 : 2'(sel - 6);
      w   = 1'($urandom_range(0, 1));
      issue(w, s, 8'($urandom_range(0, 15)), 8'($urandom), bit'($urandom_range(0, 1)), 1);
    end
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
